// File: rtl/lsu_exec_if.sv
// LSU execution-side bus: store-buffer write port, dcache load port
// and CDB writeback port, seen from the LSU (master) or its peers (slave).
interface lsu_exec_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int SB_W   = 4
);
    logic                  sb_we_o;
    logic [SB_W-1:0]       sb_id_o;
    logic [DATA_W-1:0]     sb_addr_o;
    logic [DATA_W-1:0]     sb_data_o;
    logic [DATA_W/8-1:0]   sb_be_o;
    logic                  ld_req_valid_o;
    logic                  ld_req_ready_i;
    logic [DATA_W-1:0]     ld_req_addr_o;
    logic                  ld_resp_valid_i;
    logic [DATA_W-1:0]     ld_resp_data_i;
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [TAG_W-1:0]      wb_tag_o;
    logic [DATA_W-1:0]     wb_data_o;
    logic                  wb_exc_o;

    modport master (
        output sb_we_o, sb_id_o, sb_addr_o, sb_data_o, sb_be_o,
        output ld_req_valid_o, ld_req_addr_o,
        input  ld_req_ready_i, ld_resp_valid_i, ld_resp_data_i,
        output wb_valid_o, wb_tag_o, wb_data_o, wb_exc_o,
        input  wb_ready_i
    );

    modport slave (
        input  sb_we_o, sb_id_o, sb_addr_o, sb_data_o, sb_be_o,
        input  ld_req_valid_o, ld_req_addr_o,
        output ld_req_ready_i, ld_resp_valid_i, ld_resp_data_i,
        input  wb_valid_o, wb_tag_o, wb_data_o, wb_exc_o,
        output wb_ready_i
    );
endinterface

// File: rtl/lsu_exec.sv
// LSU execute stage: address gen, store-buffer write, dcache load, CDB wb.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{XLEN: 32};

    typedef struct packed {
        logic [31:0] imm;
        logic        is_store;
        logic [1:0]  lsu_size;
        logic        lsu_unsigned;
    } uop_t;
endpackage

module lsu_exec #(
    parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
    parameter int DATA_W = int'(Cfg.XLEN),
    parameter int TAG_W  = 6,
    parameter int SB_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                lsu_en,
    input  config_pkg::uop_t    lsu_uop,
    input  logic [DATA_W-1:0]   lsu_v1,
    input  logic [DATA_W-1:0]   lsu_v2,
    input  logic [TAG_W-1:0]    lsu_dst,
    input  logic [SB_W-1:0]     lsu_sb_id,
    output logic                fu_ready_o,
    lsu_exec_if.master          bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int BE_W  = DATA_W / 8;
    localparam int BW2   = 2 * BE_W;
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE, ST, LREQ, LWAIT, DRAIN, WB
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [SB_W-1:0]     sb_id_q, sb_id_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   v2_q, v2_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   eff_addr;
    logic [OFF_W-1:0]    off;
    logic [OFF_W+2:0]    shamt;

    assign imm_ext  = DATA_W'(signed'(lsu_uop.imm));
    assign eff_addr = lsu_v1 + imm_ext;
    assign off      = addr_q[OFF_W-1:0];
    assign shamt    = {off, 3'b000};

    // Load alignment: shift the lane down, then mask and extend by size.
    logic [DATA_W-1:0]   ld_shift, keep, one_w, ld_ext;
    logic [6:0]          nbits;
    logic [IDX_W-1:0]    top_idx;
    logic                sbit;

    always_comb begin
        one_w    = {{(DATA_W-1){1'b0}}, 1'b1};
        ld_shift = bus.ld_resp_data_i >> shamt;
        nbits    = 7'd8 << size_q;
        keep     = (one_w << nbits) - one_w;
        if (int'(nbits) >= DATA_W) begin
            top_idx = IDX_W'(DATA_W - 1);
        end else begin
            top_idx = IDX_W'(int'(nbits) - 1);
        end
        sbit   = ld_shift[top_idx] & ~uns_q;
        ld_ext = (ld_shift & keep) | (sbit ? ~keep : '0);
    end

    logic [BW2-1:0]      one_b, be_w;
    logic [3:0]          nbytes;

    always_comb begin
        one_b  = {{(BW2-1){1'b0}}, 1'b1};
        nbytes = 4'd1 << size_q;
        be_w   = ((one_b << nbytes) - one_b) << off;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic                exc_q, exc_d;
    logic [3:0]          amask;
    logic                mis;

    assign amask = (4'd1 << lsu_uop.lsu_size) - 4'd1;
    assign mis   = |(eff_addr[3:0] & amask);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            sb_id_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            v2_q    <= '0;
            res_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            exc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            sb_id_q <= sb_id_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            v2_q    <= v2_d;
            res_q   <= res_d;
`ifdef LSU_MISALIGN_TRAP_EN
            exc_q   <= exc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        sb_id_d = sb_id_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        v2_d    = v2_q;
        res_d   = res_q;
`ifdef LSU_MISALIGN_TRAP_EN
        exc_d   = exc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!flush_i && lsu_en) begin
                    tag_d   = lsu_dst;
                    sb_id_d = lsu_sb_id;
                    size_d  = lsu_uop.lsu_size;
                    uns_d   = lsu_uop.lsu_unsigned;
                    addr_d  = eff_addr;
                    v2_d    = lsu_v2;
                    res_d   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    exc_d   = mis;
                    if (mis) begin
                        state_d = WB;
                    end else if (lsu_uop.is_store) begin
                        state_d = ST;
                    end else begin
                        state_d = LREQ;
                    end
`else
                    state_d = lsu_uop.is_store ? ST : LREQ;
`endif
                end
            end
            ST: begin
                state_d = flush_i ? IDLE : WB;
            end
            LREQ: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (bus.ld_req_ready_i) begin
                    state_d = LWAIT;
                end
            end
            LWAIT: begin
                // A flushed load still owes one response unless it is here now.
                if (flush_i) begin
                    state_d = bus.ld_resp_valid_i ? IDLE : DRAIN;
                end else if (bus.ld_resp_valid_i) begin
                    res_d   = ld_ext;
                    state_d = WB;
                end
            end
            DRAIN: begin
                if (bus.ld_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (flush_i || bus.wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_st, in_lreq;

    assign in_st   = (state_q == ST);
    assign in_lreq = (state_q == LREQ);

    assign fu_ready_o         = (state_q == IDLE);
    assign bus.sb_we_o        = in_st & ~flush_i;
    assign bus.sb_id_o        = in_st ? sb_id_q : '0;
    assign bus.sb_addr_o      = in_st ? addr_q : '0;
    assign bus.sb_data_o      = in_st ? (v2_q << shamt) : '0;
    assign bus.sb_be_o        = in_st ? be_w[BE_W-1:0] : '0;
    assign bus.ld_req_valid_o = in_lreq & ~flush_i;
    assign bus.ld_req_addr_o  = in_lreq ?
                                {addr_q[DATA_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.wb_valid_o     = (state_q == WB) & ~flush_i;
    assign bus.wb_tag_o       = tag_q;
    assign bus.wb_data_o      = res_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.wb_exc_o       = exc_q;
`else
    assign bus.wb_exc_o       = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_exec.sv
// Directed plus random bench for lsu_exec against a byte-level model.
// Build with LSU_MISALIGN_TRAP_EN defined to cover the trap path.
module tb_lsu_exec;
    import config_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        lsu_en;
    uop_t        lsu_uop;
    logic [31:0] lsu_v1;
    logic [31:0] lsu_v2;
    logic [5:0]  lsu_dst;
    logic [3:0]  lsu_sb_id;
    logic        fu_ready_o;

    int total = 0;
    int bad   = 0;
    int hs    = 0;

    lsu_exec_if #(.DATA_W(32), .TAG_W(6), .SB_W(4)) bus ();

    lsu_exec #(.DATA_W(32), .TAG_W(6), .SB_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .lsu_en     (lsu_en),
        .lsu_uop    (lsu_uop),
        .lsu_v1     (lsu_v1),
        .lsu_v2     (lsu_v2),
        .lsu_dst    (lsu_dst),
        .lsu_sb_id  (lsu_sb_id),
        .fu_ready_o (fu_ready_o),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.ld_req_valid_o && bus.ld_req_ready_i) hs <= hs + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] addr,
                                           input logic [31:0] word,
                                           input int sz, input bit uns);
        int off, n;
        longint v, m;
        off = int'(addr % 4);
        n   = 1 << sz;
        v   = 0;
        for (int i = 0; i < n; i++)
            if (off + i < 4)
                v += longint'((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
        m = longint'(1) << (8 * n);
        if (!uns && v >= m / 2) v -= m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input int sz);
        int v;
        v = (((1 << (1 << sz)) - 1) << int'(addr % 4)) & 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_sdata(input logic [31:0] addr,
                                            input logic [31:0] v2);
        longint v;
        v = (longint'(v2) << (8 * int'(addr % 4))) & 64'hFFFF_FFFF;
        return v[31:0];
    endfunction

    function automatic bit misal(input logic [31:0] addr, input int sz);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % (1 << sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic issue(input logic [31:0] v1, input logic [31:0] imm,
                         input logic [31:0] v2, input bit st, input int sz,
                         input bit uns, input logic [5:0] tag,
                         input logic [3:0] sb);
        lsu_en                = 1'b1;
        lsu_uop.imm           = imm;
        lsu_uop.is_store      = st;
        lsu_uop.lsu_size      = sz[1:0];
        lsu_uop.lsu_unsigned  = uns;
        lsu_v1                = v1;
        lsu_v2                = v2;
        lsu_dst               = tag;
        lsu_sb_id             = sb;
        tick();
        lsu_en = 1'b0;
    endtask

    task automatic wb_phase(input string tg, input logic [5:0] tag,
                            input logic [31:0] data, input bit exc,
                            input int hold);
        chk({tg, ".wbv"}, 64'(bus.wb_valid_o), 64'd1);
        chk({tg, ".tag"}, 64'(bus.wb_tag_o), 64'(tag));
        chk({tg, ".data"}, 64'(bus.wb_data_o), 64'(data));
        chk({tg, ".exc"}, 64'(bus.wb_exc_o), 64'(exc));
        for (int k = 0; k < hold; k++) begin
            bus.wb_ready_i = 1'b0;
            tick();
            chk({tg, ".hold_v"}, 64'(bus.wb_valid_o), 64'd1);
            chk({tg, ".hold_d"}, 64'({bus.wb_tag_o, bus.wb_data_o}),
                64'({tag, data}));
        end
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;
        chk({tg, ".rdy"}, 64'(fu_ready_o), 64'd1);
        chk({tg, ".wb0"}, 64'(bus.wb_valid_o), 64'd0);
    endtask

    task automatic do_store(input string tg, input logic [31:0] v1,
                            input logic [31:0] imm, input logic [31:0] v2,
                            input int sz, input logic [5:0] tag,
                            input logic [3:0] sb, input int hold);
        logic [31:0] a;
        a = v1 + imm;
        issue(v1, imm, v2, 1'b1, sz, 1'b0, tag, sb);
        chk({tg, ".fu0"}, 64'(fu_ready_o), 64'd0);
        if (misal(a, sz)) begin
            chk({tg, ".nowe"}, 64'(bus.sb_we_o), 64'd0);
            wb_phase(tg, tag, 32'd0, 1'b1, hold);
        end else begin
            chk({tg, ".we"}, 64'(bus.sb_we_o), 64'd1);
            chk({tg, ".id"}, 64'(bus.sb_id_o), 64'(sb));
            chk({tg, ".addr"}, 64'(bus.sb_addr_o), 64'(a));
            chk({tg, ".be"}, 64'(bus.sb_be_o), 64'(m_be(a, sz)));
            chk({tg, ".sdat"}, 64'(bus.sb_data_o), 64'(m_sdata(a, v2)));
            tick();
            chk({tg, ".we1"}, 64'(bus.sb_we_o), 64'd0);
            wb_phase(tg, tag, 32'd0, 1'b0, hold);
        end
    endtask

    task automatic do_load(input string tg, input logic [31:0] v1,
                           input logic [31:0] imm, input int sz, input bit uns,
                           input logic [5:0] tag, input logic [31:0] resp,
                           input int rlat, input int plat, input int hold);
        logic [31:0] a;
        int h0;
        a  = v1 + imm;
        h0 = hs;
        issue(v1, imm, 32'd0, 1'b0, sz, uns, tag, 4'd0);
        if (misal(a, sz)) begin
            chk({tg, ".noreq"}, 64'(bus.ld_req_valid_o), 64'd0);
            wb_phase(tg, tag, 32'd0, 1'b1, hold);
            chk({tg, ".nohs"}, 64'(hs), 64'(h0));
            return;
        end
        for (int k = 0; k < rlat; k++) begin
            chk({tg, ".rqv"}, 64'(bus.ld_req_valid_o), 64'd1);
            chk({tg, ".rqa"}, 64'(bus.ld_req_addr_o), 64'(a & 32'hFFFF_FFFC));
            tick();
        end
        chk({tg, ".rqv"}, 64'(bus.ld_req_valid_o), 64'd1);
        chk({tg, ".rqa"}, 64'(bus.ld_req_addr_o), 64'(a & 32'hFFFF_FFFC));
        bus.ld_req_ready_i = 1'b1;
        tick();
        bus.ld_req_ready_i = 1'b0;
        chk({tg, ".rq0"}, 64'(bus.ld_req_valid_o), 64'd0);
        for (int k = 0; k < plat; k++) begin
            tick();
            chk({tg, ".nowb"}, 64'(bus.wb_valid_o), 64'd0);
        end
        bus.ld_resp_valid_i = 1'b1;
        bus.ld_resp_data_i  = resp;
        tick();
        bus.ld_resp_valid_i = 1'b0;
        chk({tg, ".hs"}, 64'(hs), 64'(h0 + 1));
        wb_phase(tg, tag, m_load(a, resp, sz, uns), 1'b0, hold);
    endtask

    task automatic to_lwait(input logic [31:0] v1);
        issue(v1, 32'd0, 32'd0, 1'b0, 2, 1'b0, 6'd9, 4'd0);
        bus.ld_req_ready_i = 1'b1;
        tick();
        bus.ld_req_ready_i = 1'b0;
    endtask

    initial begin
        flush_i = 0; lsu_en = 0; lsu_uop = '0;
        lsu_v1 = 0; lsu_v2 = 0; lsu_dst = 0; lsu_sb_id = 0;
        bus.ld_req_ready_i = 0; bus.ld_resp_valid_i = 0;
        bus.ld_resp_data_i = 0; bus.wb_ready_i = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("rst.fu", 64'(fu_ready_o), 64'd1);
        chk("rst.we", 64'(bus.sb_we_o), 64'd0);
        chk("rst.rq", 64'(bus.ld_req_valid_o), 64'd0);
        chk("rst.wb", 64'(bus.wb_valid_o), 64'd0);
        chk("rst.out", 64'({bus.wb_tag_o, bus.wb_data_o, bus.wb_exc_o,
            bus.sb_be_o, bus.sb_addr_o}), 64'd0);
        #2 rst_n = 1'b1;
        tick();

        do_store("sw", 32'h1000, 32'd4, 32'hDEAD_BEEF, 2, 6'd5, 4'd3, 0);
        do_load("lb", 32'h2000, 32'd3, 0, 1'b0, 6'd7, 32'h8011_2233, 0, 0, 0);
        chk("lb.val", 64'(m_load(32'h2003, 32'h8011_2233, 0, 0)),
            64'hFFFF_FF80);
        do_load("lbu", 32'h2000, 32'd3, 0, 1'b1, 6'd8, 32'h8011_2233, 0, 1, 0);
        do_load("lh", 32'h2000, 32'd2, 1, 1'b0, 6'd10, 32'h8011_2233, 3, 2, 1);
        do_load("lw_mis", 32'h1000, 32'd2, 2, 1'b0, 6'd11, 32'hCAFE_F00D,
                0, 0, 2);
        do_store("sh_mis", 32'h1000, 32'd3, 32'h0000_A5B6, 1, 6'd12, 4'd1, 2);

        // flush in LWAIT, response four cycles later
        to_lwait(32'h3000);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drain.fu", 64'(fu_ready_o), 64'd0);
            chk("drain.wb", 64'(bus.wb_valid_o), 64'd0);
            if (k < 2) tick();
        end
        tick();
        bus.ld_resp_valid_i = 1'b1;
        bus.ld_resp_data_i  = 32'h1234_5678;
        chk("drain.fu_r", 64'(fu_ready_o), 64'd0);
        tick();
        bus.ld_resp_valid_i = 1'b0;
        chk("drain.end", 64'(fu_ready_o), 64'd1);
        chk("drain.wb1", 64'(bus.wb_valid_o), 64'd0);
        do_load("post", 32'h4000, 32'd1, 0, 1'b1, 6'd13, 32'h0000_9900, 1, 0, 0);

        // response and flush together
        to_lwait(32'h3100);
        flush_i = 1'b1;
        bus.ld_resp_valid_i = 1'b1;
        tick();
        flush_i = 1'b0;
        bus.ld_resp_valid_i = 1'b0;
        chk("rf.fu", 64'(fu_ready_o), 64'd1);
        chk("rf.wb", 64'(bus.wb_valid_o), 64'd0);

        // flush in IDLE blocks the accept
        lsu_en = 1'b1; lsu_uop.is_store = 1'b1; flush_i = 1'b1;
        tick();
        lsu_en = 1'b0; flush_i = 1'b0;
        chk("fi.fu", 64'(fu_ready_o), 64'd1);
        chk("fi.we", 64'(bus.sb_we_o), 64'd0);

        // flush in ST
        issue(32'h500, 32'd0, 32'h11, 1'b1, 2, 1'b0, 6'd1, 4'd2);
        flush_i = 1'b1;
        #1 chk("fs.we", 64'(bus.sb_we_o), 64'd0);
        tick();
        flush_i = 1'b0;
        chk("fs.fu", 64'(fu_ready_o), 64'd1);
        chk("fs.wb", 64'(bus.wb_valid_o), 64'd0);

        // flush in LREQ
        begin
            int h0;
            h0 = hs;
            issue(32'h600, 32'd0, 32'd0, 1'b0, 2, 1'b0, 6'd2, 4'd0);
            flush_i = 1'b1;
            bus.ld_req_ready_i = 1'b1;
            #1 chk("fl.rq", 64'(bus.ld_req_valid_o), 64'd0);
            tick();
            flush_i = 1'b0;
            bus.ld_req_ready_i = 1'b0;
            chk("fl.fu", 64'(fu_ready_o), 64'd1);
            chk("fl.hs", 64'(hs), 64'(h0));
        end

        // flush in WB
        issue(32'h700, 32'd0, 32'h22, 1'b1, 2, 1'b0, 6'd3, 4'd4);
        tick();
        chk("fw.wb", 64'(bus.wb_valid_o), 64'd1);
        flush_i = 1'b1;
        #1 chk("fw.drop", 64'(bus.wb_valid_o), 64'd0);
        tick();
        flush_i = 1'b0;
        chk("fw.fu", 64'(fu_ready_o), 64'd1);

        // stray response in IDLE
        bus.ld_resp_valid_i = 1'b1;
        tick();
        bus.ld_resp_valid_i = 1'b0;
        chk("stray.fu", 64'(fu_ready_o), 64'd1);
        chk("stray.wb", 64'(bus.wb_valid_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] v1, imm, v2;
            int sz;
            bit st, uns;
            v1  = $urandom;
            imm = $urandom_range(0, 15);
            v2  = $urandom;
            sz  = $urandom_range(0, 2);
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            if (st)
                do_store("rnd_st", v1, imm, v2, sz, 6'($urandom),
                         4'($urandom), $urandom_range(0, 2));
            else
                do_load("rnd_ld", v1, imm, sz, uns, 6'($urandom), $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 2));
        end

        // reset while waiting for a response
        to_lwait(32'h3200);
        rst_n = 1'b0;
        #1 chk("rw.fu", 64'(fu_ready_o), 64'd1);
        #3 rst_n = 1'b1;
        bus.ld_resp_valid_i = 1'b1;
        bus.ld_resp_data_i  = 32'hFFFF_FFFF;
        tick();
        bus.ld_resp_valid_i = 1'b0;
        chk("rw.wb", 64'(bus.wb_valid_o), 64'd0);
        chk("rw.fu1", 64'(fu_ready_o), 64'd1);
        do_load("rw.next", 32'h3300, 32'd0, 2, 1'b0, 6'd4, 32'h0BAD_F00D,
                0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
